// File: rtl/fifo_rd_stream_adapter.sv
// Drains a synchronous FIFO read port into a valid/ready stream with burst framing.
// A 2-entry skid buffer absorbs the FIFO's one-cycle read latency for full throughput.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_read_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  burst_count
);

  localparam logic [CNT_WIDTH-1:0] BEAT_MAX = CNT_WIDTH'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] data0_q, data0_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic                  last0_q, last0_d;
  logic                  last1_q, last1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
  logic [CNT_WIDTH-1:0]  burst_count_q, burst_count_d;

  logic                  pop;
  logic                  cap_last;
  logic [2:0]            level;

  // Read issue, capture into the tail, head advance on pop, and counters.
  always_comb begin
    pop      = (occ_q != 2'd0) && m_ready;
    // Post-pop occupancy including the word already on its way from the FIFO.
    level    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_read_en = !reset && enable && !fifo_empty && (level < 3'd2);
    cap_last = (beat_q == BEAT_MAX);

    data0_d       = data0_q;
    data1_d       = data1_q;
    last0_d       = last0_q;
    last1_d       = last1_q;
    occ_d         = occ_q;
    inflight_d    = fifo_read_en;
    beat_d        = beat_q;
    word_count_d  = word_count_q;
    burst_count_d = burst_count_q;

    if (inflight_q) begin
      beat_d = cap_last ? {CNT_WIDTH{1'b0}} : beat_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      beat_d = beat_q;
    end

    case ({pop, inflight_q})
      2'b10: begin
        data0_d = data1_q;
        last0_d = last1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd0) begin
          data0_d = fifo_data_out;
          last0_d = cap_last;
        end else begin
          data1_d = fifo_data_out;
          last1_d = cap_last;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = fifo_data_out;
          last1_d = cap_last;
        end else begin
          data0_d = fifo_data_out;
          last0_d = cap_last;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase

    if (pop) begin
      word_count_d = word_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (last0_q) begin
        burst_count_d = burst_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        burst_count_d = burst_count_q;
      end
    end else begin
      word_count_d = word_count_q;
    end
  end

  // State registers; reset also discards any word still returning from the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      data0_q       <= {DATA_WIDTH{1'b0}};
      data1_q       <= {DATA_WIDTH{1'b0}};
      last0_q       <= 1'b0;
      last1_q       <= 1'b0;
      occ_q         <= 2'd0;
      inflight_q    <= 1'b0;
      beat_q        <= {CNT_WIDTH{1'b0}};
      word_count_q  <= {CNT_WIDTH{1'b0}};
      burst_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      data0_q       <= data0_d;
      data1_q       <= data1_d;
      last0_q       <= last0_d;
      last1_q       <= last1_d;
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
      beat_q        <= beat_d;
      word_count_q  <= word_count_d;
      burst_count_q <= burst_count_d;
    end
  end

  assign m_valid     = (occ_q != 2'd0);
  assign m_data      = data0_q;
  assign m_last      = last0_q;
  assign word_count  = word_count_q;
  assign burst_count = burst_count_q;

endmodule
